// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the dual-port FIFO memory: read pointer, occupancy
// tracking from writer strobes, and a registered valid/ready output stage.
module fifo_read_ctrl #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we_dual,
  input  logic [DW-1:0] dout_dual,
  output logic [AW-1:0] addr_rd,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          dual_empty,
  output logic          dual_full,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic          wr_acc;
  logic          fetch;
  logic [AW:0]   count_next;

  always_comb begin
    dual_empty = (count == '0);
    dual_full  = (count == DEPTH);
    wr_acc     = we_dual & ~dual_full;
    // A word written this cycle is not yet fetchable: fetch only sees registered count.
    fetch      = ~dual_empty & (~out_valid | out_ready);
    count_next = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, fetch};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_rd   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      addr_rd   <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      count <= count_next;
      if (we_dual && dual_full)
        overflow <= 1'b1;
      if (fetch) begin
        out_data  <= dout_dual;
        out_valid <= 1'b1;
        addr_rd   <= addr_rd + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl with a behavioural 8x4 memory.
module tb_fifo_read_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       we_dual;
  logic [3:0] dout_dual;
  logic [2:0] addr_rd;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       dual_empty;
  logic       dual_full;
  logic       overflow;

  logic [3:0] wdata;
  logic [2:0] addr_wr;
  logic [3:0] mem [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DW(4), .AW(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we_dual(we_dual), .dout_dual(dout_dual),
    .addr_rd(addr_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .dual_empty(dual_empty),
    .dual_full(dual_full), .overflow(overflow)
  );

  // Writer + memory model: writer honours dual_full, so dropped writes never land.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_wr <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (clr) begin
      addr_wr <= '0;
    end else if (we_dual && !dual_full) begin
      mem[addr_wr] <= wdata;
      addr_wr      <= addr_wr + 3'd1;
    end
  end

  assign dout_dual = mem[addr_rd];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1'b1; we_dual = 1'b0; out_ready = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; clr = 1'b0; we_dual = 1'b0; out_ready = 1'b0; wdata = '0;
    #12;
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || addr_rd !== 3'd0 || out_data !== 4'd0 ||
        overflow !== 1'b0 || dual_empty !== 1'b1 || dual_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d valid=%b addr=%0d data=%h ovf=%b e=%b f=%b required 0 0 0 0 0 1 0",
               count, out_valid, addr_rd, out_data, overflow, dual_empty, dual_full);
    end
  endtask

  task automatic test_single_word;
    we_dual = 1'b1; wdata = 4'hA; out_ready = 1'b1;
    tick();
    we_dual = 1'b0;
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_write count=%0d valid=%b required 1 0", count, out_valid);
    end
    tick();
    checks++;
    if (out_data !== 4'hA || out_valid !== 1'b1 || count !== 4'd0 || addr_rd !== 3'd1) begin
      errors++;
      $display("FAIL single_fetch data=%h valid=%b count=%0d addr=%0d required a 1 0 1",
               out_data, out_valid, count, addr_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hA) begin
      errors++;
      $display("FAIL single_drain valid=%b data=%h required 0 a", out_valid, out_data);
    end
  endtask

  task automatic test_fill_full;
    do_clr();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      we_dual = 1'b1; wdata = 4'(i);
      tick();
    end
    checks++;
    if (count !== 4'd7 || out_data !== 4'd1 || out_valid !== 1'b1 || dual_full !== 1'b0) begin
      errors++;
      $display("FAIL fill_8 count=%0d data=%h valid=%b full=%b required 7 1 1 0",
               count, out_data, out_valid, dual_full);
    end
    wdata = 4'd9;
    tick();
    checks++;
    if (count !== 4'd8 || dual_full !== 1'b1 || overflow !== 1'b0 || addr_wr !== addr_rd) begin
      errors++;
      $display("FAIL fill_full count=%0d full=%b ovf=%b addr_rd=%0d required 8 1 0 1",
               count, dual_full, overflow, addr_rd);
    end
    wdata = 4'd10;
    tick();
    we_dual = 1'b0;
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1 || dual_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow count=%0d ovf=%b full=%b required 8 1 1", count, overflow, dual_full);
    end
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_data !== 4'd1 || out_valid !== 1'b1 || addr_rd !== 3'd1 || count !== 4'd8) begin
        errors++;
        $display("FAIL stall_%0d data=%h valid=%b addr=%0d count=%0d required 1 1 1 8",
                 i, out_data, out_valid, addr_rd, count);
      end
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      tick();
      checks++;
      if (out_data !== 4'(i) || out_valid !== 1'b1 || count !== 4'(9 - i)) begin
        errors++;
        $display("FAIL drain_%0d data=%h valid=%b count=%0d required %h 1 %0d",
                 i, out_data, out_valid, count, 4'(i), 9 - i);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || dual_empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end valid=%b empty=%b ovf=%b required 0 1 1", out_valid, dual_empty, overflow);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      we_dual = 1'b1; wdata = 4'(i + 3);
      tick();
    end
    we_dual = 1'b0;
    checks++;
    if (count !== 4'd5 || out_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre count=%0d valid=%b ovf=%b required 5 1 1", count, out_valid, overflow);
    end
    clr = 1'b1; we_dual = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; we_dual = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || addr_rd !== 3'd0 ||
        out_data !== 4'd0 || dual_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush count=%0d valid=%b ovf=%b addr=%0d data=%h empty=%b required 0 0 0 0 0 1",
               count, out_valid, overflow, addr_rd, out_data, dual_empty);
    end
  endtask

  task automatic test_wrap_stream;
    do_clr();
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      we_dual = 1'b1; wdata = 4'(k + 5);
      tick();
      if (k >= 2) begin
        checks++;
        if (out_data !== 4'(k + 4) || out_valid !== 1'b1 || count !== 4'd1 ||
            addr_rd !== 3'(k - 1)) begin
          errors++;
          $display("FAIL stream_%0d data=%h valid=%b count=%0d addr=%0d required %h 1 1 %0d",
                   k, out_data, out_valid, count, addr_rd, 4'(k + 4), 3'(k - 1));
        end
      end
    end
    we_dual = 1'b0;
    tick();
    checks++;
    if (out_data !== 4'(25) || count !== 4'd0 || addr_rd !== 3'd4) begin
      errors++;
      $display("FAIL stream_last data=%h count=%0d addr=%0d required 9 0 4", out_data, count, addr_rd);
    end
  endtask

  task automatic test_async_reset;
    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we_dual = 1'b1; wdata = 4'hC;
      tick();
    end
    we_dual = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || addr_rd !== 3'd0 || count !== 4'd0 || dual_empty !== 1'b1 ||
        out_data !== 4'd0) begin
      errors++;
      $display("FAIL async_reset valid=%b addr=%0d count=%0d empty=%b data=%h required 0 0 0 1 0",
               out_valid, addr_rd, count, dual_empty, out_data);
    end
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL post_reset valid=%b count=%0d required 0 0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_full();
    test_back_pressure();
    test_flush();
    test_wrap_stream();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
